// File: rtl/datapath_pkg.sv
// Shared datapath constants, MIPS opcode encodings and the ID/EX bundle layout.
package datapath_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned OPW    = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPW-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
        logic [AW-1:0]     dest;
        logic [OPW-1:0]    opcode;
        logic [OPW-1:0]    funct;
        logic              regWrite;
        logic              isLoad;
        logic              isStore;
    } id_ex_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-source operand select: $0 -> zero, then EX forward, then WB forward, then register file.
module operand_forward_mux
    import datapath_pkg::*;
(
    input  logic [AW-1:0]     srcAddr,
    input  logic [DATA_W-1:0] rfData,
    input  logic              exFwdEn,
    input  logic [AW-1:0]     exFwdAddr,
    input  logic [DATA_W-1:0] exFwdData,
    input  logic              wbFwdEn,
    input  logic [AW-1:0]     wbFwdAddr,
    input  logic [DATA_W-1:0] wbFwdData,
    output logic [DATA_W-1:0] operand_c
);

    always_comb begin
        operand_c = rfData;
        if (srcAddr == AW'(0)) begin
            operand_c = '0;
        end else if (exFwdEn && (exFwdAddr == srcAddr)) begin
            operand_c = exFwdData;
        end else if (wbFwdEn && (wbFwdAddr == srcAddr)) begin
            operand_c = wbFwdData;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes a fetched instruction, forwards operands, detects
// load-use hazards and registers the ID/EX bundle behind a valid/ready handshake.
module decode_issue_stage
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic [AW-1:0]     rf_raddr1,
    output logic [AW-1:0]     rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              ex_fwd_en,
    input  logic [AW-1:0]     ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [AW-1:0]     wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_dest,
    output logic [OPW-1:0]    out_opcode,
    output logic [OPW-1:0]    out_funct,
    output logic              out_reg_write,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic [31:0]       stall_count
);

    logic [OPW-1:0]    opcode;
    logic [AW-1:0]     rs, rt, rd;
    logic [15:0]       imm16;
    logic              useRs, useRt, regWrite, isLoad, isStore;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] fwd1_c, fwd2_c;
    logic              hazard, accept;
    id_ex_t            nextBundle, idEx;
    logic              outValid;
    logic [31:0]       stallCount;

    assign opcode    = in_instr[31:26];
    assign rs        = in_instr[25:21];
    assign rt        = in_instr[20:16];
    assign rd        = in_instr[15:11];
    assign imm16     = in_instr[15:0];
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Field decode; unknown opcodes fall through as a NOP with no sources.
    always_comb begin
        useRs    = 1'b0;
        useRt    = 1'b0;
        regWrite = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        dest     = rt;
        immExt   = {{(DATA_W-16){imm16[15]}}, imm16};
        case (opcode)
            OP_RTYPE: begin
                useRs    = 1'b1;
                useRt    = 1'b1;
                regWrite = 1'b1;
                dest     = rd;
            end
            OP_LW: begin
                useRs    = 1'b1;
                regWrite = 1'b1;
                isLoad   = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                useRs    = 1'b1;
                regWrite = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                useRs    = 1'b1;
                regWrite = 1'b1;
                immExt   = {{(DATA_W-16){1'b0}}, imm16};
            end
            OP_LUI: begin
                useRs    = 1'b1;
                regWrite = 1'b1;
                immExt   = {imm16, {(DATA_W-16){1'b0}}};
            end
            OP_SW: begin
                useRs   = 1'b1;
                useRt   = 1'b1;
                isStore = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                useRs = 1'b1;
                useRt = 1'b1;
            end
            default: ;
        endcase
        if (!regWrite) begin
            dest = '0;
        end
    end

    operand_forward_mux u_fwd1 (
        .srcAddr   (rs),
        .rfData    (rf_rdata1),
        .exFwdEn   (ex_fwd_en),
        .exFwdAddr (ex_fwd_addr),
        .exFwdData (ex_fwd_data),
        .wbFwdEn   (wb_fwd_en),
        .wbFwdAddr (wb_fwd_addr),
        .wbFwdData (wb_fwd_data),
        .operand_c (fwd1_c)
    );

    operand_forward_mux u_fwd2 (
        .srcAddr   (rt),
        .rfData    (rf_rdata2),
        .exFwdEn   (ex_fwd_en),
        .exFwdAddr (ex_fwd_addr),
        .exFwdData (ex_fwd_data),
        .wbFwdEn   (wb_fwd_en),
        .wbFwdAddr (wb_fwd_addr),
        .wbFwdData (wb_fwd_data),
        .operand_c (fwd2_c)
    );

    always_comb begin
        nextBundle          = '0;
        nextBundle.op1      = useRs ? fwd1_c : '0;
        nextBundle.op2      = useRt ? fwd2_c : '0;
        nextBundle.imm      = immExt;
        nextBundle.dest     = dest;
        nextBundle.opcode   = opcode;
        nextBundle.funct    = in_instr[5:0];
        nextBundle.regWrite = regWrite;
        nextBundle.isLoad   = isLoad;
        nextBundle.isStore  = isStore;
    end

    // A load still in the output register cannot forward its data yet.
    assign hazard = outValid && idEx.isLoad && (idEx.dest != AW'(0)) &&
                    ((useRs && (idEx.dest == rs)) || (useRt && (idEx.dest == rt)));

    assign in_ready = flush || ((!outValid || out_ready) && !hazard);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx       <= '0;
            outValid   <= 1'b0;
            stallCount <= '0;
        end else begin
            if (flush) begin
                outValid <= 1'b0;
            end else if (accept) begin
                idEx     <= nextBundle;
                outValid <= 1'b1;
            end else if (out_ready) begin
                outValid <= 1'b0;
            end
            if (!flush && hazard && in_valid && out_ready && (stallCount != 32'hFFFF_FFFF)) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end

    assign out_valid     = outValid;
    assign out_op1       = idEx.op1;
    assign out_op2       = idEx.op2;
    assign out_imm       = idEx.imm;
    assign out_dest      = idEx.dest;
    assign out_opcode    = idEx.opcode;
    assign out_funct     = idEx.funct;
    assign out_reg_write = idEx.regWrite;
    assign out_is_load   = idEx.isLoad;
    assign out_is_store  = idEx.isStore;
    assign stall_count   = stallCount;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage.
module tb_decode_issue_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_instr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_fwd_en, wb_fwd_en;
    logic [4:0]  ex_fwd_addr, wb_fwd_addr;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_imm;
    logic [4:0]  out_dest;
    logic [5:0]  out_opcode, out_funct;
    logic        out_reg_write, out_is_load, out_is_store;
    logic [31:0] stall_count;

    int checks = 0;
    int failures = 0;

    decode_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_imm(out_imm), .out_dest(out_dest), .out_opcode(out_opcode), .out_funct(out_funct),
        .out_reg_write(out_reg_write), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_fwd_en = 1'b0; ex_fwd_addr = 5'd0; ex_fwd_data = 32'd0;
        wb_fwd_en = 1'b0; wb_fwd_addr = 5'd0; wb_fwd_data = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
        rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
        clear_fwd();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
        checks++; if ({out_op1, out_op2, out_imm} !== 96'd0) begin failures++; $display("FAIL reset_ops got=%h exp=0", {out_op1, out_op2, out_imm}); end
        checks++; if ({out_dest, out_opcode, out_funct, out_reg_write, out_is_load, out_is_store} !== 20'd0) begin failures++; $display("FAIL reset_ctl got=%h exp=0", {out_dest, out_opcode, out_funct, out_reg_write, out_is_load, out_is_store}); end
        checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL reset_stall got=%h exp=0", stall_count); end
        rst_n = 1'b1;
        tick();
    endtask

    // add $3,$1,$2
    task automatic test_rtype();
        in_valid = 1'b1; in_instr = 32'h0022_1820; rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
        #1;
        checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin failures++; $display("FAIL raddr got=%h/%h exp=1/2", rf_raddr1, rf_raddr2); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rtype_ready got=%h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid got=%h exp=1", out_valid); end
        checks++; if ({out_op1, out_op2} !== {32'd5, 32'd7}) begin failures++; $display("FAIL rtype_ops got=%h/%h exp=5/7", out_op1, out_op2); end
        checks++; if ({out_dest, out_reg_write, out_opcode, out_funct} !== {5'd3, 1'b1, 6'h00, 6'h20}) begin failures++; $display("FAIL rtype_ctl got=%h/%h/%h/%h exp=3/1/00/20", out_dest, out_reg_write, out_opcode, out_funct); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rtype_drain got=%h exp=0", out_valid); end
    endtask

    task automatic test_forward();
        in_valid = 1'b1; in_instr = 32'h0022_1820; rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
        ex_fwd_en = 1'b1; ex_fwd_addr = 5'd1; ex_fwd_data = 32'hAA;
        wb_fwd_en = 1'b1; wb_fwd_addr = 5'd1; wb_fwd_data = 32'hBB;
        tick();
        checks++; if (out_op1 !== 32'hAA) begin failures++; $display("FAIL fwd_ex_prio got=%h exp=aa", out_op1); end
        ex_fwd_en = 1'b0; wb_fwd_addr = 5'd2; wb_fwd_data = 32'hCC;
        tick();
        checks++; if ({out_op1, out_op2} !== {32'd5, 32'hCC}) begin failures++; $display("FAIL fwd_wb got=%h/%h exp=5/cc", out_op1, out_op2); end
        // add $3,$1,$0 with a forward aimed at $0
        in_instr = 32'h0020_1820; rf_rdata2 = 32'd9;
        ex_fwd_en = 1'b1; ex_fwd_addr = 5'd0; ex_fwd_data = 32'h55;
        wb_fwd_en = 1'b0;
        tick();
        checks++; if (out_op2 !== 32'd0) begin failures++; $display("FAIL fwd_zero got=%h exp=0", out_op2); end
        in_valid = 1'b0; clear_fwd();
        tick();
    endtask

    // lw $4,0($1) then add $5,$4,$2
    task automatic test_load_use();
        in_valid = 1'b1; in_instr = 32'h8C24_0000; rf_rdata1 = 32'h100;
        tick();
        checks++; if ({out_valid, out_is_load, out_dest} !== {1'b1, 1'b1, 5'd4}) begin failures++; $display("FAIL lw_issue got=%h/%h/%h exp=1/1/4", out_valid, out_is_load, out_dest); end
        in_instr = 32'h0082_2820; rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'd2;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hazard_ready got=%h exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%h exp=0", out_valid); end
        checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL bubble_stall got=%h exp=1", stall_count); end
        wb_fwd_en = 1'b1; wb_fwd_addr = 5'd4; wb_fwd_data = 32'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL after_bubble_ready got=%h exp=1", in_ready); end
        tick();
        checks++; if ({out_valid, out_op1, out_dest} !== {1'b1, 32'h1234, 5'd5}) begin failures++; $display("FAIL lu_issue got=%h/%h/%h exp=1/1234/5", out_valid, out_op1, out_dest); end
        checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL lu_stall_hold got=%h exp=1", stall_count); end
        clear_fwd();
    endtask

    // Output holds the add from the load-use test; addi $2,$0,-1 waits behind it.
    task automatic test_backpressure();
        out_ready = 1'b0; in_instr = 32'h2002_FFFF; rf_rdata1 = 32'h777;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%h exp=0", i, in_ready); end
            tick();
            checks++; if ({out_valid, out_op1, out_op2, out_dest, out_funct} !== {1'b1, 32'h1234, 32'd2, 5'd5, 6'h20}) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%h/%h/%h exp=1/1234/2/5", i, out_valid, out_op1, out_op2, out_dest); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%h exp=1", in_ready); end
        tick();
        checks++; if ({out_valid, out_imm, out_op1, out_dest} !== {1'b1, 32'hFFFF_FFFF, 32'd0, 5'd2}) begin failures++; $display("FAIL addi got=%h/%h/%h/%h exp=1/ffffffff/0/2", out_valid, out_imm, out_op1, out_dest); end
    endtask

    task automatic test_imm();
        in_instr = 32'h3402_FFFF;
        tick();
        checks++; if (out_imm !== 32'h0000_FFFF) begin failures++; $display("FAIL ori_imm got=%h exp=0000ffff", out_imm); end
        in_instr = 32'h3C02_1234;
        tick();
        checks++; if ({out_imm, out_dest, out_reg_write} !== {32'h1234_0000, 5'd2, 1'b1}) begin failures++; $display("FAIL lui got=%h/%h/%h exp=12340000/2/1", out_imm, out_dest, out_reg_write); end
        // j target
        in_instr = 32'h0800_0010;
        tick();
        checks++; if ({out_reg_write, out_dest, out_op1, out_op2} !== {1'b0, 5'd0, 64'd0}) begin failures++; $display("FAIL j_nop got=%h/%h/%h/%h exp=0/0/0/0", out_reg_write, out_dest, out_op1, out_op2); end
        // unknown opcode 0x3F with rt=$7
        in_instr = 32'hFC27_0000;
        tick();
        checks++; if ({out_reg_write, out_dest, out_is_load, out_is_store} !== 8'd0) begin failures++; $display("FAIL unknown_nop got=%h/%h/%h/%h exp=0", out_reg_write, out_dest, out_is_load, out_is_store); end
    endtask

    task automatic test_back_to_back();
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        in_instr = 32'h3026_8000;  // andi $6,$1,0x8000
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%h exp=1", in_ready); end
        tick();
        checks++; if ({out_imm, out_op1, out_dest} !== {32'h0000_8000, 32'h11, 5'd6}) begin failures++; $display("FAIL andi got=%h/%h/%h exp=8000/11/6", out_imm, out_op1, out_dest); end
        in_instr = 32'h2827_8000;  // slti $7,$1,-32768
        tick();
        checks++; if ({out_imm, out_dest, out_opcode} !== {32'hFFFF_8000, 5'd7, 6'h0A}) begin failures++; $display("FAIL slti got=%h/%h/%h exp=ffff8000/7/0a", out_imm, out_dest, out_opcode); end
        in_instr = 32'hAC22_0004;  // sw $2,4($1)
        tick();
        checks++; if ({out_is_store, out_reg_write, out_dest, out_op1, out_op2, out_imm} !== {1'b1, 1'b0, 5'd0, 32'h11, 32'h22, 32'd4}) begin failures++; $display("FAIL sw got=%h/%h/%h/%h/%h/%h exp=1/0/0/11/22/4", out_is_store, out_reg_write, out_dest, out_op1, out_op2, out_imm); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'h8C24_0000;
        tick();
        in_instr = 32'h0082_2820; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%h exp=1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%h exp=0", out_valid); end
        checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL flush_stall got=%h exp=1", stall_count); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr = 32'h0022_1820; rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, stall_count} !== 33'd0) begin failures++; $display("FAIL async_reset got=%h/%h exp=0/0", out_valid, stall_count); end
        checks++; if ({out_op1, out_dest} !== 37'd0) begin failures++; $display("FAIL async_reset_data got=%h/%h exp=0/0", out_op1, out_dest); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_forward();
        test_load_use();
        test_backpressure();
        test_imm();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Pipelined decode/issue stage wrapped around the 32-entry register file. Takes fetched instructions over a valid/ready handshake, drives the register-file read addresses, merges read data with forwarded results, and registers a decoded operand bundle (ID/EX register) for the execute stage. Also detects load-use hazards and inserts one bubble when one occurs.

## Interface
- DATA_W, 32, datapath width
- AW, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  fetch handshake
- in_instr  in  32  MIPS-format instruction
- flush  in  1  drop the held and incoming instruction (branch redirect)
- rf_raddr1 / rf_raddr2  out  AW  combinational, in_instr[25:21] / in_instr[20:16]
- rf_rdata1 / rf_rdata2  in  DATA_W  register-file read data, same cycle
- ex_fwd_en, ex_fwd_addr, ex_fwd_data  in  1/AW/DATA_W  EX/MEM ALU result; never asserted for loads
- wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1/AW/DATA_W  MEM/WB write-back, same value written to the register file
- out_valid / out_ready  out / in  1  execute handshake
- out_op1, out_op2, out_imm  out  DATA_W  operands and extended immediate
- out_dest  out  AW; out_opcode  out  6; out_funct  out  6
- out_reg_write, out_is_load, out_is_store  out  1 each
- stall_count  out  32  saturating count of load-use bubbles

## Operation
- Decode:
  - R-type (op 0x00): dest = rd; rs and rt are sources.
  - lw 0x23 and addi 0x08 / andi 0x0C / ori 0x0D / slti 0x0A / lui 0x0F: dest = rt; only rs is a source.
  - sw 0x2B, beq 0x04, bne 0x05: no dest; rs and rt are sources.
  - j 0x02: no sources and no dest.
- reg_write = R-type | lw | addi | andi | ori | slti | lui. Any unknown opcode decodes as a NOP: reg_write = 0, no sources.
- Immediate:
  - andi/ori: zero-extended.
  - lui: imm16 << 16.
  - All others: sign-extended.
- Operand select, per source:
  - Address 0 always yields 0.
  - Otherwise EX forward if enabled and the address matches.
  - Otherwise WB forward if enabled and the address matches.
  - Otherwise register-file data.
  - EX has priority over WB.
- out_dest = 0 whenever reg_write = 0.
- Load-use hazard:
  - Condition: out_valid, out_is_load, out_dest ≠ 0, and out_dest equals an active source of in_instr.
  - While the hazard holds, in_ready = 0.
  - If out_ready = 1 in that cycle, the output register loads a bubble (out_valid = 0), and stall_count increments (saturating at 0xFFFFFFFF).
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard.
  - The output register loads when in_valid & in_ready.
  - out_valid clears when it fires with no new input.
  - All out_* fields hold stable while out_valid & !out_ready.
- flush:
  - Next cycle out_valid = 0.
  - in_ready = 1 and the incoming instruction is discarded.
  - stall_count is not incremented.
  - flush has priority over the hazard and over capture.

## Timing
- Reset (asynchronous, rst_n low): out_valid = 0, every out_* data field = 0, stall_count = 0.
  - The bundle is cleared immediately, mid-transfer included; no transfer completes in the reset cycle.
- Latency: one cycle from in accept to out_valid.
  - Back-to-back throughput is 1 instruction/cycle with no hazards.
- rf_raddr* are purely combinational from in_instr. Forward muxing is in the same cycle as the read.
- A load followed immediately by a dependent instruction costs exactly one bubble cycle; the operand then arrives via wb_fwd.
- Simultaneous write-back and read of the same register in the register file: the wb forward path supplies the new value, so register-file write ordering is irrelevant.

## Structure
- Shared package `datapath_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_J);
  - DATA_W and AW;
  - a packed `id_ex_t` struct for the output bundle.
- One sub-module, `operand_forward_mux`: per-source zero/EX/WB/RF select. It is instantiated twice.
- Decode, hazard logic, the output register, and the counter live in the top module.

## Test plan
- `add $3,$1,$2`: rf_rdata1 = 5, rf_rdata2 = 7, no forwards → next cycle out_op1 = 5, out_op2 = 7, out_dest = 3, out_reg_write = 1.
- Same instruction with ex_fwd (addr 1, data 0xAA) and wb_fwd (addr 1, data 0xBB) → out_op1 = 0xAA. Read of $0 with a forward to addr 0 → out_op2 = 0.
- `lw $4,0($1)` then `add $5,$4,$2` with out_ready = 1:
  - cycle 2: in_ready = 0, out_valid = 0 bubble, stall_count = 1;
  - cycle 3: the add issues with out_op1 = wb_fwd_data (0x1234).
- out_ready held 0 for 3 cycles with out_valid = 1 → all out_* fields unchanged, in_ready = 0; the next instruction is accepted on the cycle out_ready rises.
- `addi $2,$0,-1` → out_imm = 0xFFFFFFFF. `ori $2,$0,0xFFFF` → 0x0000FFFF. `lui $2,0x1234` → 0x12340000.
- flush asserted while a hazard is pending → next cycle out_valid = 0, stall_count unchanged. rst_n pulsed low mid-stream → out_valid = 0 and stall_count = 0 immediately, without waiting for a clock edge.
